// File: rtl/bus_sram_tgt.sv
// bus_sram_tgt
//   Memory-mapped SRAM target on the main bus fabric. It decodes a word-aligned
//   window starting at BASE_ADDR and services single-beat reads and writes over
//   a req/ack handshake. WAIT_CYCLES wait states are inserted before the
//   acknowledge. Misaligned or out-of-window accesses are still acknowledged,
//   but with err_o set.
//
// Ports
//   clk_i    : clock
//   reset_i  : asynchronous, active-low reset (RAM contents are kept)
//   req_i    : request strobe, sampled only while idle
//   we_i     : 1 = write, 0 = read; valid with req_i
//   ad_i     : byte address; valid with req_i
//   data_i   : write data; valid with req_i
//   be_i     : byte-lane write enables; ignored on reads
//   data_o   : read data / post-write word; valid in the ack cycle, then held
//   ack_o    : single-cycle completion pulse
//   err_o    : error qualifier, valid only with ack_o
//   busy_o   : a transaction is in flight (WAIT or RESP)
module bus_sram_tgt #(
    parameter int                AD_LEN      = 32,
    parameter int                BUS_WIDTH   = 32,
    parameter logic [AD_LEN-1:0] BASE_ADDR   = '0,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AD_LEN-1:0]      ad_i,
    input  logic [BUS_WIDTH-1:0]   data_i,
    input  logic [BUS_WIDTH/8-1:0] be_i,
    output logic [BUS_WIDTH-1:0]   data_o,
    output logic                   ack_o,
    output logic                   err_o,
    output logic                   busy_o
);

    localparam int                BYTES      = BUS_WIDTH / 8;
    localparam int                IDX_W      = $clog2(DEPTH_WORDS);
    localparam int                OFF_LSB    = $clog2(BYTES);
    localparam logic [AD_LEN:0]   WIN_BYTES  = (AD_LEN + 1)'(DEPTH_WORDS * BYTES);
    localparam logic [AD_LEN-1:0] ALIGN_MASK = AD_LEN'(BYTES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]       be_q, be_d;
    logic                   err_q, err_d;
    logic [BUS_WIDTH-1:0]   hold_q, hold_d;
    logic [BUS_WIDTH-1:0]   ram_rdata_q;

    logic [BUS_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic [AD_LEN-1:0]      offset;
    logic                   in_win, misalign, dec_err;
    logic [IDX_W-1:0]       dec_idx;

    logic                   cur_we, cur_err;
    logic [IDX_W-1:0]       cur_idx;
    logic [BUS_WIDTH-1:0]   cur_wdata;
    logic [BYTES-1:0]       cur_be;
    logic                   enter_resp, ram_en, ram_wr;

    // Address decode. The unsigned offset wraps for addresses below the base,
    // so the explicit >= BASE_ADDR test is what rejects them.
    always_comb begin
        offset   = ad_i - BASE_ADDR;
        in_win   = (ad_i >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
        misalign = (ad_i & ALIGN_MASK) != '0;
        dec_err  = !in_win || misalign;
        dec_idx  = offset[OFF_LSB +: IDX_W];
    end

    // The RAM is accessed on the edge that enters RESP. With no wait states
    // that edge is the capture edge itself, so the access uses the live inputs
    // while idle and the captured copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = we_i;
            cur_err   = dec_err;
            cur_idx   = dec_idx;
            cur_wdata = data_i;
            cur_be    = be_i;
        end else begin
            cur_we    = we_q;
            cur_err   = err_q;
            cur_idx   = idx_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    // Next-state logic and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    idx_d   = dec_idx;
                    wdata_d = data_i;
                    be_d    = be_i;
                    err_d   = dec_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // reset_i gating keeps an aborted transaction from committing a write.
    always_comb begin
        enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
        ram_en     = enter_resp && reset_i;
        ram_wr     = ram_en && cur_we && !cur_err;
    end

    // Outputs come only from flops; the hold register keeps the last
    // response visible between acknowledges.
    always_comb begin
        ack_o  = (state_q == ST_RESP);
        err_o  = (state_q == ST_RESP) && err_q;
        busy_o = (state_q != ST_IDLE);
        if (state_q == ST_RESP) begin
            data_o = err_q ? '0 : ram_rdata_q;
        end else begin
            data_o = hold_q;
        end
        hold_d = (state_q == ST_RESP) ? data_o : hold_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    // Single-port synchronous RAM with byte-lane writes. The read port is
    // write-first per lane so a write returns the post-write word.
    always_ff @(posedge clk_i) begin
        if (ram_en) begin
            for (int k = 0; k < BYTES; k++) begin
                if (ram_wr && cur_be[k]) begin
                    mem[cur_idx][k*8 +: 8] <= cur_wdata[k*8 +: 8];
                    ram_rdata_q[k*8 +: 8]  <= cur_wdata[k*8 +: 8];
                end else begin
                    ram_rdata_q[k*8 +: 8]  <= mem[cur_idx][k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_sram_tgt.sv
module tb_bus_sram_tgt;

    localparam int          W     = 1;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc = 0;

    logic        t_req = 1'b0, t_we = 1'b0;
    logic [31:0] t_ad = '0, t_data = '0;
    logic [3:0]  t_be = '0;
    logic [31:0] d_o;
    logic        a_o, e_o, b_o;

    logic        x_req = 1'b0, x_we = 1'b0;
    logic [31:0] x_ad = '0, x_data = '0;
    logic [3:0]  x_be = '0;
    logic [31:0] d0, d15;
    logic        a0, e0, b0, a15, e15, b15;

    int          n_total = 0;
    int          n_bad   = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] mdl [DEPTH];

    bus_sram_tgt #(.AD_LEN(32), .BUS_WIDTH(32), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH),
                   .WAIT_CYCLES(W)) u_dut (
        .clk_i(clk), .reset_i(rst_n), .req_i(t_req), .we_i(t_we), .ad_i(t_ad),
        .data_i(t_data), .be_i(t_be), .data_o(d_o), .ack_o(a_o), .err_o(e_o), .busy_o(b_o));

    bus_sram_tgt #(.AD_LEN(32), .BUS_WIDTH(32), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH),
                   .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .reset_i(rst_n), .req_i(x_req), .we_i(x_we), .ad_i(x_ad),
        .data_i(x_data), .be_i(x_be), .data_o(d0), .ack_o(a0), .err_o(e0), .busy_o(b0));

    bus_sram_tgt #(.AD_LEN(32), .BUS_WIDTH(32), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH),
                   .WAIT_CYCLES(15)) u_w15 (
        .clk_i(clk), .reset_i(rst_n), .req_i(x_req), .we_i(x_we), .ad_i(x_ad),
        .data_i(x_data), .be_i(x_be), .data_o(d15), .ack_o(a15), .err_o(e15), .busy_o(b15));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a word array addressed by plain byte arithmetic.
    // Returns the expected response and applies any write.
    function automatic exp_t model(input logic we, input logic [31:0] ad, input logic [31:0] d,
                                   input logic [3:0] be, input int unsigned due);
        exp_t   r;
        longint off;
        int     idx;
        off   = longint'(ad) - longint'(BASE);
        r.cyc = due;
        if (off < 0 || off >= longint'(DEPTH * 4) || (ad % 4) != 0) begin
            r.err  = 1'b1;
            r.data = '0;
        end else begin
            idx = int'(off / 4);
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
            end
            r.err  = 1'b0;
            r.data = mdl[idx];
        end
        return r;
    endfunction

    // Scoreboard monitor: every ack pops one expected response.
    always @(negedge clk) begin
        if (rst_n && a_o) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", 32'(a_o), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("data_o", d_o, mon_e.data);
                chk("err_o", 32'(e_o), 32'(mon_e.err));
                chk("ack_cycle", cyc, mon_e.cyc);
                chk("busy_at_ack", 32'(b_o), 32'd1);
            end
        end
    end

    task automatic wait_ack();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_o) return;
        end
        chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic xact(input logic we, input logic [31:0] ad, input logic [31:0] d,
                        input logic [3:0] be);
        @(negedge clk);
        t_req = 1'b1; t_we = we; t_ad = ad; t_data = d; t_be = be;
        sbq.push_back(model(we, ad, d, be, cyc + 1 + W));
        @(posedge clk);
        #1;
        // Scramble inputs: the target must not resample them while busy.
        t_req = 1'b0; t_we = 1'($urandom); t_ad = $urandom; t_data = $urandom;
        t_be = 4'($urandom);
        wait_ack();
    endtask

    task automatic x_run(input logic we, input logic [31:0] ad, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e);
        int unsigned n;
        bit got0, got15, busy_ok;
        @(negedge clk);
        x_req = 1'b1; x_we = we; x_ad = ad; x_data = d; x_be = 4'hF;
        n = cyc + 1;
        @(posedge clk);
        #1;
        x_req = 1'b0;
        got0 = 0; got15 = 0; busy_ok = 1;
        for (int i = 0; i < 30 && !(got0 && got15); i++) begin
            @(negedge clk);
            if (!got15 && !b15) busy_ok = 0;
            if (a0 && !got0) begin
                got0 = 1;
                chk("w0_ack_cycle", cyc, n);
                chk("w0_data", d0, exp_d);
                chk("w0_err", 32'(e0), 32'(exp_e));
            end
            if (a15 && !got15) begin
                got15 = 1;
                chk("w15_ack_cycle", cyc, n + 15);
                chk("w15_data", d15, exp_d);
                chk("w15_err", 32'(e15), 32'(exp_e));
            end
        end
        if (!got0)  chk("w0_ack_timeout", 32'd0, 32'd1);
        if (!got15) chk("w15_ack_timeout", 32'd0, 32'd1);
        chk("w15_busy_throughout", 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, w5;
        int          r;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(a_o), 32'd0);
        chk("rst_err", 32'(e_o), 32'd0);
        chk("rst_busy", 32'(b_o), 32'd0);
        chk("rst_data", d_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full write, readback, byte-enable merge
        xact(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        xact(1'b0, BASE + 32'h10, 32'h0, 4'h0);
        xact(1'b1, BASE + 32'h10, 32'h11223344, 4'b0101);
        xact(1'b0, BASE + 32'h10, 32'h0, 4'hF);

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) xact(1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

        // Error responses, word 0 must stay intact
        xact(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF);
        xact(1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF);
        xact(1'b0, BASE - 32'h4, 32'h0, 4'hF);
        xact(1'b0, BASE, 32'h0, 4'h0);

        // Back-to-back reads of words 0..3 with req held high
        @(negedge clk);
        t_req = 1'b1; t_we = 1'b0; t_ad = BASE; t_be = 4'hF;
        sbq.push_back(model(1'b0, BASE, 32'h0, 4'hF, cyc + 1 + W));
        for (int i = 0; i < 4; i++) begin
            wait_ack();
            if (i < 3) begin
                t_ad = BASE + 32'(4 * (i + 1));
                sbq.push_back(model(1'b0, t_ad, 32'h0, 4'hF, cyc + 2 + W));
            end else begin
                t_req = 1'b0;
            end
        end

        // Reset during the wait state of a write to word 5
        w5 = mdl[5];
        @(negedge clk);
        t_req = 1'b1; t_we = 1'b1; t_ad = BASE + 32'd20; t_data = ~w5; t_be = 4'hF;
        @(posedge clk);
        #1;
        t_req = 1'b0;
        chk("busy_in_wait", 32'(b_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(b_o), 32'd0);
        chk("abort_ack", 32'(a_o), 32'd0);
        chk("abort_data", d_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(a_o), 32'd0);
        end
        xact(1'b0, BASE + 32'd20, 32'h0, 4'hF);

        // Randomized mix of hits, misaligned, below-window and beyond-window
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 6) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (r == 7) a = BASE - 32'(4 * $urandom_range(1, 8));
            else if (r == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
            else             a = $urandom;
            xact(1'($urandom), a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Zero and fifteen wait-state builds
        x_run(1'b1, BASE + 32'h8, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
        x_run(1'b0, BASE + 32'h8, 32'h0, 32'hA5A5_5A5A, 1'b0);
        x_run(1'b0, BASE - 32'h4, 32'h0, 32'h0, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
